// File: rtl/regfile_seq.sv
// Micro-sequencer for the 4-bit regA/regB/ALU datapath on a shared tristate bus.
// Instructions arrive through a 2-entry FIFO and retire in DECODE/EXEC pairs.
module regfile_seq (
    input  logic       clk,
    input  logic       grst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [3:0] in_imm,
    input  logic       hold,
    output logic [3:0] imm_o,
    output logic       rs1,
    output logic       rs2,
    output logic       ws1,
    output logic       rs3,
    output logic       rs4,
    output logic       ws2,
    output logic       lrst_a,
    output logic       lrst_b,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       out_ld,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] imm;
    } instr_t;

    typedef struct packed {
        logic rs1, rs2, ws1;
        logic rs3, rs4, ws2;
        logic lrst_a, lrst_b;
        logic alu_oe, alu_sub, out_ld;
        logic done, err;
    } strb_t;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;

    state_t     state, state_nxt;
    instr_t     fifo [2];
    logic       wp, rp;
    logic [1:0] cnt;
    logic       push, pop;
    logic [3:0] ir_op, ir_imm;
    strb_t      strb, strb_nxt;

    // in_ready looks only at the count, so a full FIFO refuses even while popping
    assign in_ready = (cnt != 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE || state == EXEC) && (cnt != 2'd0);
    assign busy     = (state != IDLE) || (cnt != 2'd0);
    assign imm_o    = ir_imm;

    always_ff @(posedge clk) begin
        if (push) fifo[wp] <= '{op: in_op, imm: in_imm};
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            ir_op  <= 4'd0;
            ir_imm <= 4'd0;
        end else if (pop) begin
            ir_op  <= fifo[rp].op;
            ir_imm <= fifo[rp].imm;
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cnt != 2'd0) state_nxt = DECODE;
            DECODE:  if (!hold)       state_nxt = EXEC;
            EXEC:    state_nxt = (cnt != 2'd0) ? DECODE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are only ever loaded on DECODE->EXEC; every other edge clears them,
    // which keeps the bus driver-free in DECODE.
    always_comb begin
        strb_nxt = '0;
        if (state == DECODE && !hold) begin
            strb_nxt.done = 1'b1;
            case (ir_op)
                4'd0: ;
                4'd1: strb_nxt.rs1 = 1'b1;
                4'd2: strb_nxt.rs3 = 1'b1;
                4'd3: begin strb_nxt.ws1 = 1'b1; strb_nxt.rs4 = 1'b1; end
                4'd4: begin strb_nxt.ws2 = 1'b1; strb_nxt.rs2 = 1'b1; end
                4'd5: begin strb_nxt.alu_oe = 1'b1; strb_nxt.rs2 = 1'b1; end
                4'd6: begin
                    strb_nxt.alu_oe  = 1'b1;
                    strb_nxt.rs2     = 1'b1;
                    strb_nxt.alu_sub = 1'b1;
                end
                4'd7: strb_nxt.lrst_a = 1'b1;
                4'd8: strb_nxt.lrst_b = 1'b1;
                4'd9: begin strb_nxt.ws1 = 1'b1; strb_nxt.out_ld = 1'b1; end
                default: strb_nxt.err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge grst) begin
        if (grst) strb <= '0;
        else      strb <= strb_nxt;
    end

    assign rs1     = strb.rs1;
    assign rs2     = strb.rs2;
    assign ws1     = strb.ws1;
    assign rs3     = strb.rs3;
    assign rs4     = strb.rs4;
    assign ws2     = strb.ws2;
    assign lrst_a  = strb.lrst_a;
    assign lrst_b  = strb.lrst_b;
    assign alu_oe  = strb.alu_oe;
    assign alu_sub = strb.alu_sub;
    assign out_ld  = strb.out_ld;
    assign done    = strb.done;
    assign err     = strb.err;

endmodule

// File: doc/regfile_seq.md
# regfile_seq

Micro-sequencer for the 4-bit register file and ALU on the shared tristate data bus. It accepts 4-bit opcodes plus a 4-bit immediate through a valid/ready handshake and buffers them in a 2-entry FIFO. It executes them one at a time by pulsing the load, drive and local-reset strobes of regA, regB, the ALU and the output latch. It guarantees at most one bus driver per cycle and a driver-free guard cycle between instructions.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- grst  in  1  reset, asynchronous, active-high; clears all state and strobes.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept; high when FIFO count < 2.
- in_op  in  4  opcode.
- in_imm  in  4  immediate.
- hold  in  1  stall; freezes the sequencer in DECODE.
- imm_o  out  4  immediate of the current instruction, to regA/regB imm inputs.
- rs1, rs2, ws1  out  1 each  regA: load imm, load bus, drive bus.
- rs3, rs4, ws2  out  1 each  regB: load imm, load bus, drive bus.
- lrst_a, lrst_b  out  1 each  regA/regB synchronous local clear.
- alu_oe  out  1  ALU drives its result onto the bus.
- alu_sub  out  1  ALU mode: 0 = A+B, 1 = A−B (mod 16).
- out_ld  out  1  output port latches the bus.
- busy  out  1  high when the state is not IDLE or the FIFO is non-empty.
- done  out  1  one-cycle pulse during each EXEC cycle.
- err  out  1  one-cycle pulse during EXEC of an illegal opcode.

## Operation
- FIFO: 2 entries, each {op, imm}.
  - Push when in_valid && in_ready at a clock edge.
  - in_ready depends only on the count, so a full FIFO refuses a push even in a cycle that pops.
  - Push and pop in the same cycle with count 1 keeps count 1; order is preserved.
- FSM states: IDLE, DECODE, EXEC.
  - IDLE → DECODE when the FIFO is non-empty; pop the head into ir_op/ir_imm.
  - DECODE → EXEC when hold = 0; stay in DECODE while hold = 1.
  - EXEC → DECODE, popping the next entry, if the FIFO is non-empty; otherwise EXEC → IDLE.
- Strobes are registered. They are loaded on the DECODE→EXEC edge and cleared on the EXEC exit edge, so they are high for exactly the one EXEC cycle. All strobes are 0 in IDLE and DECODE.
- imm_o is registered and loaded with ir_imm on pop. It holds that value through EXEC and until the next pop.
- Opcode decode (strobes active during EXEC):
  - 0 NOP: none.
  - 1 LDA: rs1.
  - 2 LDB: rs3.
  - 3 MAB (A→B): ws1, rs4.
  - 4 MBA (B→A): ws2, rs2.
  - 5 ADD (A←A+B): alu_oe, rs2, alu_sub=0.
  - 6 SUB (A←A−B): alu_oe, rs2, alu_sub=1.
  - 7 CLRA: lrst_a.
  - 8 CLRB: lrst_b.
  - 9 OUTA: ws1, out_ld.
  - 10–15: illegal. No strobes; err pulses; the instruction still retires and done pulses.
- Invariant: at most one of ws1, ws2, alu_oe is high in any cycle. Every DECODE cycle has all three low, giving the bus turnaround.

## Timing
- Reset values: state IDLE, FIFO empty, in_ready=1, imm_o=0, every strobe 0, busy=0, done=0, err=0.
- grst asserted mid-instruction:
  - Strobes drop asynchronously and FIFO contents are discarded.
  - No partial load is guaranteed; a register update on the same edge as the grst assertion is not required.
- Latency: push accepted at edge k into an empty FIFO in IDLE.
  - DECODE from edge k+1.
  - EXEC from edge k+2.
  - Target register updates at edge k+3.
- Throughput: one instruction per 2 cycles while the FIFO stays non-empty and hold=0.
- hold is sampled only in DECODE. Asserting hold during EXEC has no effect until the next DECODE.
- A push into an empty FIFO in the same cycle as EXEC→IDLE is not popped until the next IDLE→DECODE edge, so the sequencer spends one IDLE cycle.
- busy falls in the first IDLE cycle with an empty FIFO.

## Test plan
- Reset: assert grst mid-EXEC of ADD. Strobes go to 0 immediately; after release in_ready=1 and busy=0.
- Single LDA: LDA imm=0xA pushed at edge k into IDLE.
  - rs1=1 only during cycle k+2..k+3, imm_o=0xA.
  - done pulses once; no other strobes.
- Back-to-back: push LDA 3, LDB 5, ADD, OUTA as fast as in_ready allows.
  - Strobe sequence rs1 | rs3 | alu_oe+rs2 | ws1+out_ld, each separated by one strobe-free DECODE cycle.
  - in_ready deasserts when 2 entries are queued; the bus is never driven in a DECODE cycle.
- Bus exclusivity: random opcode stream of 200 instructions. Assert every cycle that ws1+ws2+alu_oe ≤ 1 and that strobes occur only in EXEC.
- Hold: hold=1 for 5 cycles while in DECODE of MAB. ws1/rs4 stay 0 until one cycle after hold falls, then are high for exactly 1 cycle.
- Illegal/boundary:
  - Opcode 0xF gives err=1, done=1, no strobes.
  - SUB with imm-loaded A=2, B=5 gives alu_sub=1 during EXEC (expected A=0xD).
  - Push while full with simultaneous pop is rejected (in_ready=0).
